// File: rtl/tc_pkg.sv
// Shared definitions for the tc_array timer/counter peripheral:
// channel state encoding, register map, CTRL field layout and mode encodings.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PS_LSB   = 8;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // Only the exact auto-reload encoding reloads; every other value is one-shot.
    function automatic logic mode_is_auto(input logic [1:0] mode);
        return (mode == MODE_AUTO);
    endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler and the
// IDLE/LOAD/CNT/INT control FSM.
module tc_channel
    import tc_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_we,
    input  logic        preset_we,
    input  logic        status_we,
    input  logic [31:0] wdata,
    input  logic [1:0]  rsel,
    output logic [31:0] rdata,
    output logic        irq
);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic                    en_r;
    logic [1:0]              mode_r;
    logic                    im_r;
    logic [PRESCALE_W-1:0]   prescale_r;
    logic [31:0]             preset_r;
    logic [31:0]             count_r;
    logic                    status_r;
    logic [PRESCALE_W-1:0]   pscnt_r;

    logic                    en_eff_s;
    logic                    tick_s;
    logic                    load_s;
    logic                    dec_s;
    logic                    expire_s;
    logic                    ps_run_s;
    logic                    clr_en_s;
    logic [31:0]             ctrl_rd_s;

    // A CTRL write in flight overrides the stored enable so EN=0 stops the FSM on the write edge.
    assign en_eff_s = ctrl_we ? wdata[CTRL_EN_BIT] : en_r;
    assign tick_s   = (pscnt_r == prescale_r);
    assign irq      = status_r & im_r;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en_eff_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (en_eff_s) begin
                    state_nxt_s = ST_CNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CNT: begin
                if (!en_eff_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_s && (count_r <= 32'd1)) begin
                    state_nxt_s = ST_INT;
                end else begin
                    state_nxt_s = ST_CNT;
                end
            end
            ST_INT: begin
                if (en_eff_s && mode_is_auto(mode_r)) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath strobes for the current state
    always_comb begin
        load_s   = 1'b0;
        dec_s    = 1'b0;
        expire_s = 1'b0;
        ps_run_s = 1'b0;
        clr_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = 1'b0;
            end
            ST_LOAD: begin
                load_s = en_eff_s;
            end
            ST_CNT: begin
                if (en_eff_s) begin
                    ps_run_s = 1'b1;
                    if (tick_s) begin
                        if (count_r <= 32'd1) begin
                            expire_s = 1'b1;
                        end else begin
                            dec_s = 1'b1;
                        end
                    end else begin
                        dec_s = 1'b0;
                    end
                end else begin
                    ps_run_s = 1'b0;
                end
            end
            ST_INT: begin
                clr_en_s = ~mode_is_auto(mode_r);
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Control register; a software write beats the one-shot enable clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r       <= 1'b0;
            mode_r     <= 2'b00;
            im_r       <= 1'b0;
            prescale_r <= {PRESCALE_W{1'b0}};
        end else if (ctrl_we) begin
            en_r       <= wdata[CTRL_EN_BIT];
            mode_r     <= wdata[CTRL_MODE_LSB +: 2];
            im_r       <= wdata[CTRL_IM_BIT];
            prescale_r <= wdata[CTRL_PS_LSB +: PRESCALE_W];
        end else if (clr_en_s) begin
            en_r <= 1'b0;
        end else begin
            en_r <= en_r;
        end
    end

    // Reload value, only consumed in LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset_r <= 32'd0;
        end else if (preset_we) begin
            preset_r <= wdata;
        end else begin
            preset_r <= preset_r;
        end
    end

    // Down-counter and prescale divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 32'd0;
            pscnt_r <= {PRESCALE_W{1'b0}};
        end else begin
            if (load_s) begin
                count_r <= preset_r;
            end else if (expire_s) begin
                count_r <= 32'd0;
            end else if (dec_s) begin
                count_r <= count_r - 32'd1;
            end else begin
                count_r <= count_r;
            end

            if (load_s) begin
                pscnt_r <= {PRESCALE_W{1'b0}};
            end else if (ps_run_s) begin
                pscnt_r <= tick_s ? {PRESCALE_W{1'b0}} : pscnt_r + PRESCALE_W'(1);
            end else begin
                pscnt_r <= pscnt_r;
            end
        end
    end

    // Sticky done flag; a hardware expiry beats a same-cycle write-1-to-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_r <= 1'b0;
        end else if (expire_s) begin
            status_r <= 1'b1;
        end else if (status_we && wdata[0]) begin
            status_r <= 1'b0;
        end else begin
            status_r <= status_r;
        end
    end

    // CTRL readback image, unused bits read zero
    always_comb begin
        ctrl_rd_s                              = 32'd0;
        ctrl_rd_s[CTRL_EN_BIT]                 = en_r;
        ctrl_rd_s[CTRL_MODE_LSB +: 2]          = mode_r;
        ctrl_rd_s[CTRL_IM_BIT]                 = im_r;
        ctrl_rd_s[CTRL_PS_LSB +: PRESCALE_W]   = prescale_r;
    end

    // Register read mux
    always_comb begin
        case (rsel)
            REG_CTRL:   rdata = ctrl_rd_s;
            REG_PRESET: rdata = preset_r;
            REG_COUNT:  rdata = count_r;
            REG_STATUS: rdata = {31'd0, status_r};
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/tc_array.sv
// Multi-channel timer/counter: word-addressed register window decoding into
// CHANNELS independent tc_channel instances, with per-channel and combined IRQ.
module tc_array
    import tc_pkg::*;
#(
    parameter  int CHANNELS   = 2,
    parameter  int PRESCALE_W = 8,
    localparam int ADDR_W     = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any
);

    logic [ADDR_W-1:0] chan_s;
    logic [1:0]        rsel_s;
    logic [31:0]       ch_rd_s [CHANNELS];

    // Shifting keeps the channel field valid even when CHANNELS=1 leaves no channel bits.
    assign chan_s  = addr >> 2;
    assign rsel_s  = addr[1:0];
    assign irq_any = |irq;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic hit_s;

        // Out-of-range channel numbers match no instance, so their writes vanish.
        assign hit_s = we & (chan_s == ADDR_W'(i));

        tc_channel #(
            .PRESCALE_W (PRESCALE_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .ctrl_we   (hit_s & (rsel_s == REG_CTRL)),
            .preset_we (hit_s & (rsel_s == REG_PRESET)),
            .status_we (hit_s & (rsel_s == REG_STATUS)),
            .wdata     (wdata),
            .rsel      (rsel_s),
            .rdata     (ch_rd_s[i]),
            .irq       (irq[i])
        );
    end

    // Read mux: OR of masked channel data, zero for unpopulated channels
    always_comb begin
        rdata = 32'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            rdata = rdata | (ch_rd_s[i] & {32{chan_s == ADDR_W'(i)}});
        end
    end

endmodule

// File: tb/tb_tc_array.sv
// Directed self-checking bench for tc_array with three channels.
module tb_tc_array;

    localparam int CH = 3;
    localparam int PW = 8;
    localparam int AW = 4;
    localparam int R_CTRL   = 0;
    localparam int R_PRESET = 1;
    localparam int R_COUNT  = 2;
    localparam int R_STATUS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [CH-1:0] irq;
    logic          irq_any;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    tc_array #(
        .CHANNELS   (CH),
        .PRESCALE_W (PW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_any (irq_any)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a write; it commits on the next rising edge, returns on the following falling edge.
    task automatic wr(input int ch, input int r, input logic [31:0] d);
        addr  = AW'(ch * 4 + r);
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        addr = AW'(ch * 4 + r);
        #1;
        v = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                checks++;
                if (v !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_reg ch%0d r%0d got %h exp 0", c, r, v);
                end
            end
        end
        checks++;
        if (irq !== 3'b000 || irq_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b/%b exp 000/0", irq, irq_any);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(0, R_PRESET, 32'd5);
        wr(0, R_CTRL, 32'h0000_0009);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            rd(0, R_COUNT, v);
            checks++;
            if (v !== 32'(6 - k)) begin
                errors++;
                $display("FAIL oneshot_count E%0d got %0d exp %0d", k, v, 6 - k);
            end
            rd(0, R_STATUS, v);
            checks++;
            if (v !== ((k == 6) ? 32'd1 : 32'd0) || irq[0] !== (k == 6)) begin
                errors++;
                $display("FAIL oneshot_status E%0d got %0d irq %b", k, v, irq[0]);
            end
        end
        step(1);
        rd(0, R_CTRL, v);
        checks++;
        if (v !== 32'h0000_0008) begin
            errors++;
            $display("FAIL oneshot_ctrl got %h exp 00000008", v);
        end
        step(3);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL oneshot_hold got %0d exp 0", v);
        end
        wr(0, R_STATUS, 32'd1);
        rd(0, R_STATUS, v);
        checks++;
        if (v !== 32'd0 || irq !== 3'b000) begin
            errors++;
            $display("FAIL oneshot_w1c got %0d irq %b exp 0 000", v, irq);
        end
    endtask

    task automatic test_autoreload;
        logic [31:0] v;
        int exp_cnt[12] = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 2, 2};
        wr(1, R_PRESET, 32'd2);
        wr(1, R_CTRL, 32'h0000_030B);
        for (int k = 0; k < 12; k++) begin
            step(1);
            rd(1, R_COUNT, v);
            checks++;
            if (v !== 32'(exp_cnt[k])) begin
                errors++;
                $display("FAIL auto_count E%0d got %0d exp %0d", k + 1, v, exp_cnt[k]);
            end
            checks++;
            if (irq[1] !== (k >= 8) || irq_any !== (k >= 8)) begin
                errors++;
                $display("FAIL auto_irq E%0d got %b/%b exp %0d", k + 1, irq[1], irq_any, k >= 8);
            end
        end
        wr(1, R_STATUS, 32'd1);
        rd(1, R_STATUS, v);
        checks++;
        if (v !== 32'd0 || irq_any !== 1'b0) begin
            errors++;
            $display("FAIL auto_w1c got %0d irq_any %b exp 0 0", v, irq_any);
        end
        wr(1, R_CTRL, 32'd0);
    endtask

    task automatic test_mask_race;
        logic [31:0] v;
        wr(0, R_PRESET, 32'd1);
        wr(0, R_CTRL, 32'h0000_0003);
        step(2);
        rd(0, R_STATUS, v);
        checks++;
        if (v !== 32'd1 || irq !== 3'b000 || irq_any !== 1'b0) begin
            errors++;
            $display("FAIL mask got %0d irq %b/%b exp 1 000/0", v, irq, irq_any);
        end
        step(2);
        wr(0, R_STATUS, 32'd1);
        rd(0, R_STATUS, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL w1c_race got %0d exp 1", v);
        end
        wr(0, R_STATUS, 32'd1);
        rd(0, R_STATUS, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL w1c_plain got %0d exp 0", v);
        end
        wr(0, R_CTRL, 32'd0);
        rd(0, R_STATUS, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL stop_status got %0d exp 0", v);
        end
    endtask

    task automatic test_ctrl_race;
        logic [31:0] v;
        wr(2, R_PRESET, 32'd1);
        wr(2, R_CTRL, 32'h0000_0001);
        step(2);
        rd(2, R_STATUS, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL ctrl_race_expire got %0d exp 1", v);
        end
        wr(2, R_CTRL, 32'h0000_0001);
        rd(2, R_CTRL, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL ctrl_race_en got %h exp 00000001", v);
        end
        step(2);
        rd(2, R_COUNT, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL ctrl_race_restart got %0d exp 1", v);
        end
        wr(2, R_CTRL, 32'd0);
        wr(2, R_STATUS, 32'd1);
    endtask

    task automatic test_pause;
        logic [31:0] v;
        wr(0, R_PRESET, 32'd9);
        wr(0, R_CTRL, 32'h0000_0001);
        step(3);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL pause_pre got %0d exp 7", v);
        end
        wr(0, R_CTRL, 32'd0);
        step(10);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL pause_hold got %0d exp 7", v);
        end
        wr(0, R_CTRL, 32'h0000_0001);
        step(1);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd9) begin
            errors++;
            $display("FAIL resume_reload got %0d exp 9", v);
        end
        wr(0, R_PRESET, 32'd100);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd8) begin
            errors++;
            $display("FAIL preset_live got %0d exp 8", v);
        end
        step(1);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd7) begin
            errors++;
            $display("FAIL preset_live2 got %0d exp 7", v);
        end
        wr(0, R_CTRL, 32'h0000_0001);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd6) begin
            errors++;
            $display("FAIL en_rewrite got %0d exp 6", v);
        end
        wr(0, R_CTRL, 32'd0);
    endtask

    task automatic test_preset_zero;
        logic [31:0] v;
        wr(2, R_PRESET, 32'd0);
        wr(2, R_CTRL, 32'h0000_0009);
        step(1);
        rd(2, R_STATUS, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL preset0_early got %0d exp 0", v);
        end
        step(1);
        rd(2, R_STATUS, v);
        checks++;
        if (v !== 32'd1 || irq !== 3'b100) begin
            errors++;
            $display("FAIL preset0_expire got %0d irq %b exp 1 100", v, irq);
        end
    endtask

    task automatic test_decode;
        logic [31:0] v;
        logic [31:0] exp_ctrl[3] = '{32'h0, 32'h0, 32'h8};
        wr(3, R_CTRL, 32'h0000_0009);
        for (int r = 0; r < 4; r++) begin
            rd(3, r, v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL decode_ch3 r%0d got %h exp 0", r, v);
            end
        end
        for (int c = 0; c < CH; c++) begin
            rd(c, R_CTRL, v);
            checks++;
            if (v !== exp_ctrl[c]) begin
                errors++;
                $display("FAIL decode_ctrl ch%0d got %h exp %h", c, v, exp_ctrl[c]);
            end
        end
        wr(1, R_COUNT, 32'h55);
        rd(1, R_COUNT, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL count_ro got %0d exp 2", v);
        end
    endtask

    task automatic test_reset_midcount;
        logic [31:0] v;
        wr(0, R_PRESET, 32'd10);
        wr(0, R_CTRL, 32'h0000_0009);
        step(8);
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd3 || irq !== 3'b100) begin
            errors++;
            $display("FAIL midcount_pre got %0d irq %b exp 3 100", v, irq);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (irq !== 3'b000 || irq_any !== 1'b0) begin
            errors++;
            $display("FAIL async_irq got %b/%b exp 000/0", irq, irq_any);
        end
        rd(0, R_COUNT, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL async_count got %0d exp 0", v);
        end
        test_reset();
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = 32'd0;
        #3;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1);
        test_oneshot();
        test_autoreload();
        test_mask_race();
        test_ctrl_race();
        test_pause();
        test_preset_zero();
        test_decode();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_array.md
Name: tc_array

Overview:
- Parametrised multi-channel timer/counter peripheral; successor to the fixed two-instance timer pair on the CPU bridge.
- Provides CHANNELS independent down-counters behind one word-addressed register window.
- Each channel has a prescaler, one-shot or auto-reload mode, sticky write-1-to-clear status, and a maskable IRQ.
- Per-channel IRQs and an OR-reduced IRQ feed the CPU interrupt inputs through the bridge.

Parameters:
- CHANNELS, 2, number of timer channels (1..16).
- PRESCALE_W, 8, width of the per-channel prescale divider field.
- ADDR_W, clog2(CHANNELS)+2, derived localparam; word address width, not overridable.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  word address; [ADDR_W-1:2]=channel, [1:0]=register
- we  in  1  write strobe, sampled at rising clk
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr
- irq  out  CHANNELS  per-channel interrupt, irq[i] = status[i] & ctrl[i].IM
- irq_any  out  1  OR of irq

Behaviour:
- Register offsets per channel:
  - 0 CTRL: [0] EN; [2:1] MODE, 00 one-shot, 01 auto-reload, 1x treated as one-shot; [3] IM; [8+PRESCALE_W-1:8] PRESCALE; other bits read 0.
  - 1 PRESET: 32-bit reload value.
  - 2 COUNT: read-only.
  - 3 STATUS: [0] sticky done flag, write-1-to-clear.
- Writes commit on the rising clk edge. Reads are combinational.
- Channel index >= CHANNELS: read 0, write ignored. Writes to COUNT are ignored.
- Reset: all CTRL/PRESET/COUNT/STATUS and prescale counters = 0, every state = IDLE, irq = 0, irq_any = 0, rdata reflects zeroed registers.
- Per-channel FSM (IDLE, LOAD, CNT, INT):
  - IDLE: EN=1 -> LOAD. COUNT holds.
  - LOAD: COUNT<=PRESET, prescale counter<=0 -> CNT.
  - CNT: EN=0 -> IDLE, COUNT frozen. A tick occurs when prescale counter == PRESCALE; the counter then wraps to 0, otherwise it increments. Ticks therefore occur every PRESCALE+1 cycles. On tick: if COUNT<=1, COUNT<=0, STATUS<=1, go to INT; else COUNT<=COUNT-1.
  - INT: MODE one-shot -> clear EN, go to IDLE. Auto-reload -> LOAD.
- Latency, PRESCALE=0, PRESET=P>=1:
  - Enable write at edge E0; LOAD after E0; CNT with COUNT=P after E1.
  - STATUS=1 and COUNT=0 after edge E(P+1); irq visible the same cycle if IM=1.
  - Auto-reload period = P+2 cycles.
- PRESET=0 behaves as PRESET=1: INT on the first tick.
- PRESET written while running takes effect only at the next LOAD.
- Write CTRL with EN=0 in any state -> IDLE on the next edge; COUNT retained.
- Simultaneous events:
  - Hardware STATUS set and software W1C in the same cycle: set wins.
  - Software CTRL write and the INT-state EN clear in the same cycle: software value wins.
- Rewriting EN=1 while already in CNT does not restart the count.
- Reset asserted mid-count: immediate return to reset values regardless of clk.

Decomposition:
- Shared package tc_pkg holds:
  - state enum (IDLE, LOAD, CNT, INT)
  - register offsets (CTRL, PRESET, COUNT, STATUS)
  - CTRL bit positions
  - MODE encodings
- Sub-module tc_channel: one channel's registers, prescaler and FSM, parametrised by PRESCALE_W.
- tc_array: generate-instantiates CHANNELS copies; does address decode, per-channel write enables, read mux and irq_any.

Test Plan:
- Reset: assert reset mid-count with ch0 at COUNT=3 -> all registers read 0, irq=0 immediately, before any clk edge.
- One-shot: ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at E0 -> COUNT 5,4,3,2,1,0 after E1..E6. STATUS=1 and irq[0]=1 after E6. CTRL reads 0x8 after E7. COUNT stays 0.
- Auto-reload with prescale: ch1 PRESET=2, PRESCALE=3, MODE=01, IM=1 -> COUNT decrements every 4 cycles. irq[1] rises and COUNT reloads to 2. STATUS stays 1 until 0x1 is written to STATUS. irq_any tracks irq[1].
- Mask and W1C race: IM=0 -> STATUS=1 but irq=0. Write STATUS=1 on the exact cycle a new expiry sets it -> STATUS reads 1.
- Pause/resume: clear EN at COUNT=7 -> COUNT holds 7 for 10 cycles. Re-enable -> LOAD reloads PRESET, not 7. A PRESET write during CNT does not alter COUNT.
- Decode with CHANNELS=3: write to channel 3 CTRL -> no channel changes, rdata=0. Write to COUNT -> ignored.
